rr_sel3: RTL and testbench
==========================

Name: rr_sel3

Overview:
- Upstream select generator for the 3:1 channel mux stage.
- Arbitrates three request lines round-robin and drives the mux select code.
- Select codes: 0 = no channel (mux output forced 0), 1..3 = channel B1..B3.
- Each grant is held for a bounded number of cycles so one channel cannot starve the others.
- All outputs are registered; the mux consumes the select code directly.

Parameters:
- HOLD_CYCLES, 4, maximum consecutive cycles a grant is held (legal range 1..255).
- CW, $clog2(HOLD_CYCLES) with a minimum of 1, width of the hold counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  3  per-channel request; bit0 = ch1, bit1 = ch2, bit2 = ch3; level-sensitive.
- sel  output  2  mux select code: 0 idle, 1..3 granted channel.
- gnt  output  3  one-hot grant, same bit order as req; all zero when sel = 0.
- busy  output  1  high while any grant is active.
- rel  output  1  one-cycle pulse on the cycle after a grant ends.

Behaviour:
- Reset (async, rst_n = 0):
  - sel = 0, gnt = 000, busy = 0, rel = 0.
  - Hold counter = 0; last-granted pointer = 3, so channel 1 has first priority.
  - Reset asserted mid-grant clears every output immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE, on each edge:
  - If req == 000: stay in IDLE.
  - Otherwise pick the first requesting channel in order last+1, last+2, last+3 (mod 3, values 1..3).
  - Register sel = ch, set the matching gnt bit, busy = 1, counter = 0, go to GRANT.
  - Latency: req sampled high at edge N gives sel valid after edge N.
- GRANT, on each edge, with ch = current channel:
  - Release when req[ch] = 0 (early release) or counter == HOLD_CYCLES-1 (hold expiry).
  - Otherwise counter increments.
- On a release edge:
  - last = ch; rel = 1 for exactly one cycle.
  - Pick the next channel by round-robin starting after ch, over the req value sampled at that same edge.
  - If a channel is found: switch to it with no idle cycle between grants. sel, gnt and counter update at the same edge; counter = 0; stay in GRANT.
  - If no channel is found: sel = 0, gnt = 000, busy = 0, go to IDLE.
  - If ch itself is the only requester, it is re-granted and its counter restarts at 0.
- Simultaneous requests are resolved purely by round-robin order from the last-granted pointer.
- HOLD_CYCLES = 1: every grant lasts exactly one cycle and the arbiter rotates every cycle while several channels request.
- Requests that rise or fall on a non-grant channel mid-grant have no effect until the next release edge.
- sel never takes a value outside 0..3; gnt is always one-hot or zero and always consistent with sel.
- rel is combinationally independent of req; it is a registered pulse.

Decomposition:
- Shared package holds:
  - select-code constants SEL_NONE = 0, SEL_CH1 = 1, SEL_CH2 = 2, SEL_CH3 = 3;
  - the 2-bit select typedef;
  - the FSM state enum {IDLE, GRANT}.
- One sub-module, rr_pick3: combinational next-channel finder with inputs req[2:0] and start pointer, outputs found and ch[1:0]. It is reused at both the IDLE-exit and release points.
- Counter and FSM stay in the top block.

Test Plan:
- Reset, then req = 000 for 5 cycles -> sel = 0, gnt = 000, busy = 0, rel never pulses.
- HOLD_CYCLES = 4, req = 001 held -> sel = 1 for 4 cycles, rel pulse, ch1 re-granted, pattern repeats; busy stays 1.
- req = 111 held -> sel sequence 1,1,1,1,2,2,2,2,3,3,3,3,1… with no gap between grants; rel pulses at each switch.
- Grant on ch2, drop req[1] after 2 cycles while req = 100 -> next edge sel = 3 with counter reset; ch3 then held 4 cycles.
- Grant on ch1, drop all requests -> next edge sel = 0, gnt = 000, busy = 0, rel = 1 for one cycle, state IDLE.
- Assert rst_n = 0 asynchronously mid-grant on ch3 -> outputs clear immediately; after release with req = 110, first grant goes to ch2 (pointer reset to 3, so search order is 1,2,3).

Source files
------------

// File: rtl/rr_sel3_pkg.sv
// rr_sel3_pkg: shared types, select-code constants and small helpers for the
// rr_sel3 round-robin select generator and its channel picker.
//   sel_t    : 2-bit mux select code (0 = no channel, 1..3 = channel B1..B3)
//   state_t  : arbiter FSM state {IDLE, GRANT}
//   next_ch  : round-robin successor of a select code (3 -> 1, 0 -> 1)
//   req_of   : request bit belonging to a select code
//   gnt_of   : one-hot grant vector for a select code
package rr_sel3_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_NONE = 2'd0;
  localparam sel_t SEL_CH1  = 2'd1;
  localparam sel_t SEL_CH2  = 2'd2;
  localparam sel_t SEL_CH3  = 2'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Successor in the cyclic order 1 -> 2 -> 3 -> 1. A code of 0 behaves like 3
  // so that a search starting from it begins at channel 1.
  function automatic sel_t next_ch(input sel_t c);
    sel_t n;
    case (c)
      SEL_CH1: n = SEL_CH2;
      SEL_CH2: n = SEL_CH3;
      default: n = SEL_CH1;
    endcase
    return n;
  endfunction

  // Request level of the channel named by c; code 0 never requests.
  function automatic logic req_of(input logic [2:0] r, input sel_t c);
    logic b;
    case (c)
      SEL_CH1: b = r[0];
      SEL_CH2: b = r[1];
      SEL_CH3: b = r[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // One-hot grant matching a select code; all zero for SEL_NONE.
  function automatic logic [2:0] gnt_of(input sel_t c);
    logic [2:0] g;
    case (c)
      SEL_CH1: g = 3'b001;
      SEL_CH2: g = 3'b010;
      SEL_CH3: g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rr_sel3_if.sv
// rr_sel3_if: request/grant bundle between the three requesting channels and
// the rr_sel3 arbiter.
//   req  : per-channel level request (bit0 = ch1 .. bit2 = ch3)
//   sel  : registered mux select code, 0 idle, 1..3 granted channel
//   gnt  : registered one-hot grant, same bit order as req
//   busy : high while a grant is active
//   rel  : one-cycle pulse on the cycle after a grant ends
// Modports: master = requester side, slave = arbiter side.
interface rr_sel3_if;
  import rr_sel3_pkg::*;

  logic [2:0] req;
  sel_t       sel;
  logic [2:0] gnt;
  logic       busy;
  logic       rel;

  modport master (
    output req,
    input  sel,
    input  gnt,
    input  busy,
    input  rel
  );

  modport slave (
    input  req,
    output sel,
    output gnt,
    output busy,
    output rel
  );

endinterface

// File: rtl/rr_sel3_pick3.sv
// rr_pick3: combinational round-robin channel finder.
//   req   : in,  per-channel request (bit0 = ch1 .. bit2 = ch3)
//   start : in,  last-granted channel; search order is start+1, +2, +3 (mod 3)
//   found : out, some channel in the search order is requesting
//   ch    : out, first requesting channel found, SEL_NONE when found = 0
module rr_pick3
  import rr_sel3_pkg::*;
(
  input  logic [2:0] req,
  input  sel_t       start,
  output logic       found,
  output sel_t       ch
);

  sel_t cand1_s;
  sel_t cand2_s;
  sel_t cand3_s;

  // The third candidate wraps back to start itself, so a lone requester that
  // was just granted is found again.
  assign cand1_s = next_ch(start);
  assign cand2_s = next_ch(cand1_s);
  assign cand3_s = next_ch(cand2_s);

  // Priority search over the three candidates in round-robin order.
  always_comb begin
    found = 1'b0;
    ch    = SEL_NONE;
    if (req_of(req, cand1_s)) begin
      found = 1'b1;
      ch    = cand1_s;
    end else if (req_of(req, cand2_s)) begin
      found = 1'b1;
      ch    = cand2_s;
    end else if (req_of(req, cand3_s)) begin
      found = 1'b1;
      ch    = cand3_s;
    end else begin
      found = 1'b0;
      ch    = SEL_NONE;
    end
  end

endmodule

// File: rtl/rr_sel3.sv
// rr_sel3: round-robin select generator for the 3:1 channel mux stage.
// Arbitrates three level requests, holds each grant for at most HOLD_CYCLES
// cycles and drives a registered select code plus matching one-hot grant.
//   clk   : in,  rising-edge clock
//   rst_n : in,  asynchronous active-low reset
//   bus   : rr_sel3_if.slave (req in; sel, gnt, busy, rel out, all registered)
// Parameter HOLD_CYCLES (1..255): maximum consecutive cycles of one grant.
module rr_sel3
  import rr_sel3_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
)
(
  input  logic      clk,
  input  logic      rst_n,
  rr_sel3_if.slave  bus
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_CYCLES - 1);

  state_t        state_r;
  state_t        state_n_s;
  sel_t          sel_r;
  sel_t          sel_n_s;
  logic [2:0]    gnt_r;
  logic [2:0]    gnt_n_s;
  logic          busy_r;
  logic          busy_n_s;
  logic          rel_r;
  logic          rel_n_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_n_s;
  sel_t          last_r;
  sel_t          last_n_s;

  sel_t          start_s;
  logic          found_s;
  sel_t          pick_s;
  logic          release_s;

  // In IDLE the search starts after the last-granted channel; on a release
  // edge the current channel becomes the new "last", so start after it.
  assign start_s = (state_r == GRANT) ? sel_r : last_r;

  rr_pick3 u_pick (
    .req   (bus.req),
    .start (start_s),
    .found (found_s),
    .ch    (pick_s)
  );

  // A grant ends when its own request drops or its hold budget is used up.
  assign release_s = (!req_of(bus.req, sel_r)) || (cnt_r == CNT_MAX);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sel_r   <= SEL_NONE;
      gnt_r   <= 3'b000;
      busy_r  <= 1'b0;
      rel_r   <= 1'b0;
      cnt_r   <= CNT_ZERO;
      last_r  <= SEL_CH3;
    end else begin
      state_r <= state_n_s;
      sel_r   <= sel_n_s;
      gnt_r   <= gnt_n_s;
      busy_r  <= busy_n_s;
      rel_r   <= rel_n_s;
      cnt_r   <= cnt_n_s;
      last_r  <= last_n_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n_s = state_r;
    sel_n_s   = sel_r;
    gnt_n_s   = gnt_r;
    busy_n_s  = busy_r;
    rel_n_s   = 1'b0;
    cnt_n_s   = cnt_r;
    last_n_s  = last_r;

    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n_s = GRANT;
          sel_n_s   = pick_s;
          gnt_n_s   = gnt_of(pick_s);
          busy_n_s  = 1'b1;
          cnt_n_s   = CNT_ZERO;
        end else begin
          state_n_s = IDLE;
          sel_n_s   = SEL_NONE;
          gnt_n_s   = 3'b000;
          busy_n_s  = 1'b0;
          cnt_n_s   = CNT_ZERO;
        end
      end

      GRANT: begin
        if (release_s) begin
          last_n_s = sel_r;
          rel_n_s  = 1'b1;
          cnt_n_s  = CNT_ZERO;
          if (found_s) begin
            // Back-to-back handover: no idle cycle between grants.
            state_n_s = GRANT;
            sel_n_s   = pick_s;
            gnt_n_s   = gnt_of(pick_s);
            busy_n_s  = 1'b1;
          end else begin
            state_n_s = IDLE;
            sel_n_s   = SEL_NONE;
            gnt_n_s   = 3'b000;
            busy_n_s  = 1'b0;
          end
        end else begin
          cnt_n_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_n_s = IDLE;
        sel_n_s   = SEL_NONE;
        gnt_n_s   = 3'b000;
        busy_n_s  = 1'b0;
        cnt_n_s   = CNT_ZERO;
        last_n_s  = SEL_CH3;
      end
    endcase
  end

  assign bus.sel  = sel_r;
  assign bus.gnt  = gnt_r;
  assign bus.busy = busy_r;
  assign bus.rel  = rel_r;

endmodule

// File: tb/tb_rr_sel3.sv
// tb_rr_sel3: scoreboard bench for rr_sel3 (HOLD_CYCLES = 4). The stimulus
// process drives req before each rising edge and queues the hand-computed
// outputs expected after that edge; a monitor pops and compares them.
module tb_rr_sel3;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] gnt;
    logic       busy;
    logic       rel;
  } exp_t;

  logic clk;
  logic rst_n;

  rr_sel3_if bus ();

  rr_sel3 #(.HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    step_no  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] gnt_for(input logic [1:0] s);
    logic [2:0] g;
    case (s)
      2'd1: g = 3'b001;
      2'd2: g = 3'b010;
      2'd3: g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  function automatic exp_t mk(input logic [1:0] s, input logic b, input logic r);
    exp_t e;
    e.sel  = s;
    e.gnt  = gnt_for(s);
    e.busy = b;
    e.rel  = r;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.sel  = bus.sel;
    a.gnt  = bus.gnt;
    a.busy = bus.busy;
    a.rel  = bus.rel;
    return a;
  endfunction

  task automatic check(input string nm, input exp_t act, input exp_t want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got sel=%0d gnt=%b busy=%b rel=%b, want sel=%0d gnt=%b busy=%b rel=%b",
               nm, act.sel, act.gnt, act.busy, act.rel,
               want.sel, want.gnt, want.busy, want.rel);
    end
  endtask

  // Drive one request vector (called just after a falling edge) and queue the
  // outputs expected once the next rising edge has sampled it.
  task automatic step(input string tag, input logic [2:0] r,
                      input logic [1:0] s, input logic b, input logic rl);
    bus.req = r;
    step_no++;
    exp_q.push_back(mk(s, b, rl));
    name_q.push_back($sformatf("%s#%0d", tag, step_no));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: outputs are registered, so compare shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), actual(), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    bus.req = 3'b000;
    #3;
    check("reset_state", actual(), mk(2'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // No requests: stays idle, no release pulse.
    for (int i = 0; i < 5; i++) step("idle", 3'b000, 2'd0, 1'b0, 1'b0);

    // Lone ch1 request: 4-cycle grants, re-granted with a release pulse.
    step("solo1", 3'b001, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("solo1", 3'b001, 2'd1, 1'b1, 1'b0);
    step("solo1_regnt", 3'b001, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("solo1", 3'b001, 2'd1, 1'b1, 1'b0);
    step("solo1_regnt", 3'b001, 2'd1, 1'b1, 1'b1);

    // All request: ch1 finishes its hold, then 2, 3, 1 with no gap.
    for (int i = 0; i < 3; i++) step("all_ch1", 3'b111, 2'd1, 1'b1, 1'b0);
    step("all_to2", 3'b111, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("all_ch2", 3'b111, 2'd2, 1'b1, 1'b0);
    step("all_to3", 3'b111, 2'd3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("all_ch3", 3'b111, 2'd3, 1'b1, 1'b0);
    step("all_to1", 3'b111, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("all_ch1b", 3'b111, 2'd1, 1'b1, 1'b0);

    // Drop everything while ch1 is granted: back to idle with a rel pulse.
    step("drop_all", 3'b000, 2'd0, 1'b0, 1'b1);
    step("idle_after", 3'b000, 2'd0, 1'b0, 1'b0);

    // Ch2 granted, its request drops after 2 cycles while ch3 requests.
    step("ch2", 3'b010, 2'd2, 1'b1, 1'b0);
    step("ch2", 3'b010, 2'd2, 1'b1, 1'b0);
    step("early_to3", 3'b100, 2'd3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("ch3_hold", 3'b100, 2'd3, 1'b1, 1'b0);
    step("ch3_regnt", 3'b100, 2'd3, 1'b1, 1'b1);

    // Ch1 request toggling mid-grant has no effect until the release edge.
    step("noise", 3'b101, 2'd3, 1'b1, 1'b0);
    step("noise", 3'b100, 2'd3, 1'b1, 1'b0);
    step("noise", 3'b101, 2'd3, 1'b1, 1'b0);
    step("expiry_to1", 3'b101, 2'd1, 1'b1, 1'b1);

    // Move grant to ch3, then reset asynchronously in the middle of it.
    step("to3", 3'b100, 2'd3, 1'b1, 1'b1);
    step("hold3", 3'b100, 2'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", actual(), mk(2'd0, 1'b0, 1'b0));
    bus.req = 3'b110;
    @(negedge clk);
    check("reset_held", actual(), mk(2'd0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Pointer is back at 3: search order 1,2,3 picks ch2 first.
    for (int i = 0; i < 4; i++) step("post_rst2", 3'b110, 2'd2, 1'b1, 1'b0);
    step("post_rst_to3", 3'b110, 2'd3, 1'b1, 1'b1);
    step("post_rst3", 3'b110, 2'd3, 1'b1, 1'b0);

    // Every queued expectation must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
